// File: rtl/scan_sequencer.sv
// Slot-based scan sequencer: per enabled slot, loads the DAC, fires the pulser after the
// DAC settle time and opens an ADC capture window, then advances to the next enabled slot.
module scan_sequencer #(
  parameter int unsigned DAC_SETTLE_CYC = 24
) (
  input  logic        adc_clk,
  input  logic        rst_n,
  input  logic        i_sync,
  input  logic [3:0]  i_slot_en,
  input  logic [15:0] i_ts_time_0,
  input  logic [15:0] i_ts_time_1,
  input  logic [15:0] i_ts_time_2,
  input  logic [15:0] i_ts_time_3,
  input  logic [15:0] i_capt_delay,
  input  logic [15:0] i_capt_len,
  input  logic        i_clr_overrun,
  output logic [1:0]  o_slot,
  output logic        o_slot_sync,
  output logic        o_dac_load,
  output logic        o_fire,
  output logic        o_capt_en,
  output logic        o_busy,
  output logic        o_complete,
  output logic        o_overrun
);

  localparam logic [15:0] SETTLE_T  = 16'(DAC_SETTLE_CYC);
  localparam logic [17:0] SETTLE_18 = 18'(DAC_SETTLE_CYC);
  localparam logic [15:0] MIN_LEN   = 16'(DAC_SETTLE_CYC + 2);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DELAY,
    CAPTURE,
    HOLD,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] t_q, t_d;
  logic [1:0]  slot_q, slot_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] len_q, len_d;
  logic [17:0] cs_q, cs_d;
  logic [17:0] ce_q, ce_d;
  logic        ov_q, ov_d;

  logic [15:0] ts_live;
  logic [15:0] len_live;
  logic [17:0] cs_live;
  logic [17:0] ce_live;
  logic [17:0] cs_use;
  logic [17:0] ce_use;
  logic [17:0] tn;
  logic        first_cyc;
  logic        slot_end;
  logic [2:0]  pk_start;
  logic [2:0]  pk_next;
  state_t      phase_d;

  // Lowest enabled slot at index >= from; bit 2 of the result flags a hit.
  function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (m[i-1] && ((i - 1) >= 32'(from))) r = {1'b1, 2'(i - 1)};
    end
    return r;
  endfunction

  always_comb begin
    ts_live = i_ts_time_0;
    case (slot_q)
      2'd1:    ts_live = i_ts_time_1;
      2'd2:    ts_live = i_ts_time_2;
      2'd3:    ts_live = i_ts_time_3;
      default: ts_live = i_ts_time_0;
    endcase
  end

  assign len_live  = (ts_live > MIN_LEN) ? ts_live : MIN_LEN;
  assign cs_live   = SETTLE_18 + 18'd1 + {2'b00, i_capt_delay};
  assign ce_live   = cs_live + {2'b00, i_capt_len};
  assign first_cyc = (state_q == SETTLE) && (t_q == '0);

  // Window bounds are only registered at the end of the first slot cycle, so that
  // cycle must look at the live values.
  assign cs_use    = first_cyc ? cs_live : cs_q;
  assign ce_use    = first_cyc ? ce_live : ce_q;
  assign tn        = {2'b00, t_q} + 18'd1;
  assign slot_end  = (state_q != SETTLE) && (t_q == len_q - 16'd1);
  assign pk_start  = pick(i_slot_en, 3'd0);
  assign pk_next   = pick(mask_q, {1'b0, slot_q} + 3'd1);

  always_comb begin
    if (tn <= SETTLE_18)  phase_d = SETTLE;
    else if (tn < cs_use) phase_d = DELAY;
    else if (tn < ce_use) phase_d = CAPTURE;
    else                  phase_d = HOLD;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    len_d   = len_q;
    cs_d    = cs_q;
    ce_d    = ce_q;
    ov_d    = ov_q;

    if (i_sync && (state_q != IDLE)) ov_d = 1'b1;
    else if (i_clr_overrun)          ov_d = 1'b0;

    if (first_cyc) begin
      len_d = len_live;
      cs_d  = cs_live;
      ce_d  = ce_live;
    end

    case (state_q)
      IDLE: begin
        if (i_sync) begin
          mask_d = i_slot_en;
          if (pk_start[2]) begin
            state_d = SETTLE;
            t_d     = '0;
            slot_d  = pk_start[1:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      SETTLE, DELAY, CAPTURE, HOLD: begin
        if (slot_end) begin
          if (pk_next[2]) begin
            state_d = SETTLE;
            t_d     = '0;
            slot_d  = pk_next[1:0];
          end else begin
            state_d = DONE;
          end
        end else begin
          t_d     = t_q + 16'd1;
          state_d = phase_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      slot_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      cs_q    <= '0;
      ce_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cs_q    <= cs_d;
      ce_q    <= ce_d;
      ov_q    <= ov_d;
    end
  end

  assign o_slot      = slot_q;
  assign o_slot_sync = first_cyc;
  assign o_dac_load  = first_cyc;
  assign o_fire      = (state_q == SETTLE) && (t_q == SETTLE_T);
  assign o_capt_en   = (state_q == CAPTURE);
  assign o_busy      = (state_q != IDLE);
  assign o_complete  = (state_q == DONE);
  assign o_overrun   = ov_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: slot-time arithmetic model checked every cycle, directed
// scenarios with literal cycle expectations, then randomized scans.
module tb_scan_sequencer;
  localparam int S = 24;

  logic        adc_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_sync = 1'b0;
  logic [3:0]  i_slot_en = '0;
  logic [15:0] i_ts_time_0 = '0;
  logic [15:0] i_ts_time_1 = '0;
  logic [15:0] i_ts_time_2 = '0;
  logic [15:0] i_ts_time_3 = '0;
  logic [15:0] i_capt_delay = '0;
  logic [15:0] i_capt_len = '0;
  logic        i_clr_overrun = 1'b0;
  logic [1:0]  o_slot;
  logic        o_slot_sync, o_dac_load, o_fire, o_capt_en, o_busy, o_complete, o_overrun;

  int total = 0;
  int bad = 0;

  scan_sequencer #(.DAC_SETTLE_CYC(S)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .i_sync(i_sync), .i_slot_en(i_slot_en),
    .i_ts_time_0(i_ts_time_0), .i_ts_time_1(i_ts_time_1),
    .i_ts_time_2(i_ts_time_2), .i_ts_time_3(i_ts_time_3),
    .i_capt_delay(i_capt_delay), .i_capt_len(i_capt_len), .i_clr_overrun(i_clr_overrun),
    .o_slot(o_slot), .o_slot_sync(o_slot_sync), .o_dac_load(o_dac_load), .o_fire(o_fire),
    .o_capt_en(o_capt_en), .o_busy(o_busy), .o_complete(o_complete), .o_overrun(o_overrun)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot timing expressed as a cycle offset t within the slot.
  bit         m_in_slot = 0, m_done = 0, m_ov = 0;
  int         m_slot = 0, m_t = 0, m_L = 0, m_cs = 0, m_ce = 0, m_nx = 0;
  logic [3:0] m_mask = '0;

  function automatic int ts_of(input int s);
    case (s)
      1:       return int'(i_ts_time_1);
      2:       return int'(i_ts_time_2);
      3:       return int'(i_ts_time_3);
      default: return int'(i_ts_time_0);
    endcase
  endfunction

  function automatic int first_en(input logic [3:0] m, input int from);
    for (int i = from; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge adc_clk or negedge rst_n);
    if (!rst_n) begin
      m_in_slot = 0; m_done = 0; m_ov = 0; m_slot = 0; m_t = 0;
    end else begin
      if (i_sync && (m_in_slot || m_done)) m_ov = 1;
      else if (i_clr_overrun)              m_ov = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_in_slot) begin
        if (m_t == 0) begin
          m_L  = (ts_of(m_slot) > S + 2) ? ts_of(m_slot) : S + 2;
          m_cs = S + 1 + int'(i_capt_delay);
          m_ce = m_cs + int'(i_capt_len);
        end
        if (m_t == m_L - 1) begin
          m_nx = first_en(m_mask, m_slot + 1);
          if (m_nx >= 0) begin m_slot = m_nx; m_t = 0; end
          else begin m_in_slot = 0; m_done = 1; end
        end else begin
          m_t++;
        end
      end else if (i_sync) begin
        m_mask = i_slot_en;
        m_nx = first_en(m_mask, 0);
        if (m_nx >= 0) begin m_in_slot = 1; m_slot = m_nx; m_t = 0; end
        else m_done = 1;
      end
    end
  end

  logic [8:0] exp_v, act_v;
  initial forever begin
    @(negedge adc_clk);
    exp_v = {2'(m_slot),
             m_in_slot && m_t == 0,
             m_in_slot && m_t == 0,
             m_in_slot && m_t == S,
             m_in_slot && m_t > 0 && m_t >= m_cs && m_t < m_ce && m_t < m_L,
             m_in_slot || m_done,
             m_done,
             m_ov};
    act_v = {o_slot, o_slot_sync, o_dac_load, o_fire, o_capt_en, o_busy, o_complete, o_overrun};
    chk("model_outputs{slot,sync,load,fire,capt,busy,cmpl,ovr}", int'(act_v), int'(exp_v));
  end

  int sync_log[$], slot_log[$], fire_log[$], comp_log[$];
  int capt_first, capt_last, capt_cnt;

  // Pulse i_sync for edge 0 and observe cycles 1..n (cycle k follows edge k-1).
  task automatic run_scan(input int n, input int osync_at);
    sync_log.delete(); slot_log.delete(); fire_log.delete(); comp_log.delete();
    capt_first = -1; capt_last = -1; capt_cnt = 0;
    @(negedge adc_clk); i_sync = 1'b1;
    @(negedge adc_clk); i_sync = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (o_slot_sync) begin sync_log.push_back(k); slot_log.push_back(int'(o_slot)); end
      if (o_fire) fire_log.push_back(k);
      if (o_complete) comp_log.push_back(k);
      if (o_capt_en && sync_log.size() == 1) begin
        if (capt_first < 0) capt_first = k;
        capt_last = k;
        capt_cnt++;
      end
      i_sync = (k == osync_at);
      @(negedge adc_clk);
    end
    i_sync = 1'b0;
  endtask

  task automatic set_ts(input int v);
    i_ts_time_0 = 16'(v); i_ts_time_1 = 16'(v); i_ts_time_2 = 16'(v); i_ts_time_3 = 16'(v);
  endtask

  function automatic logic [15:0] rnd_param();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 16'hFFFF;
    if (r == 1) return 16'h0000;
    return 16'($urandom_range(0, 70));
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge adc_clk);
    chk("reset_outputs", int'({o_slot, o_slot_sync, o_dac_load, o_fire, o_capt_en,
                               o_busy, o_complete, o_overrun}), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge adc_clk);

    set_ts(100); i_capt_delay = 16'd10; i_capt_len = 16'd50; i_slot_en = 4'b1111;
    run_scan(405, 50);
    chk("full_sync_count", sync_log.size(), 4);
    if (sync_log.size() == 4) begin
      chk("full_sync0", sync_log[0], 1);   chk("full_sync1", sync_log[1], 101);
      chk("full_sync2", sync_log[2], 201); chk("full_sync3", sync_log[3], 301);
      chk("full_slot3", slot_log[3], 3);
    end
    chk("full_fire_count", fire_log.size(), 4);
    if (fire_log.size() == 4) begin
      chk("full_fire0", fire_log[0], 25);  chk("full_fire3", fire_log[3], 325);
    end
    chk("full_capt_first", capt_first, 36);
    chk("full_capt_last", capt_last, 85);
    chk("full_capt_cnt", capt_cnt, 50);
    chk("full_complete_count", comp_log.size(), 1);
    if (comp_log.size() == 1) chk("full_complete", comp_log[0], 401);
    chk("overrun_set", int'(o_overrun), 1);
    i_clr_overrun = 1'b1; @(negedge adc_clk); i_clr_overrun = 1'b0;
    chk("overrun_cleared", int'(o_overrun), 0);

    i_slot_en = 4'b0101;
    run_scan(205, 0);
    chk("m0101_sync_count", sync_log.size(), 2);
    if (sync_log.size() == 2) begin
      chk("m0101_sync1", sync_log[1], 101);
      chk("m0101_slot0", slot_log[0], 0); chk("m0101_slot1", slot_log[1], 2);
    end
    if (comp_log.size() == 1) chk("m0101_complete", comp_log[0], 201);
    else chk("m0101_complete_count", comp_log.size(), 1);
    chk("m0101_slot_hold", int'(o_slot), 2);

    set_ts(60); i_slot_en = 4'b0011;
    run_scan(125, 0);
    chk("trunc_capt_cnt", capt_cnt, 25);
    chk("trunc_capt_first", capt_first, 36);
    chk("trunc_capt_last", capt_last, 60);
    if (sync_log.size() == 2) chk("trunc_next_sync", sync_log[1], 61);
    else chk("trunc_sync_count", sync_log.size(), 2);

    i_slot_en = 4'b0000;
    run_scan(5, 0);
    chk("empty_no_sync", sync_log.size(), 0);
    if (comp_log.size() == 1) chk("empty_complete", comp_log[0], 1);
    else chk("empty_complete_count", comp_log.size(), 1);

    set_ts(10); i_slot_en = 4'b0001;
    run_scan(30, 0);
    if (comp_log.size() == 1) chk("short_complete", comp_log[0], 27);
    else chk("short_complete_count", comp_log.size(), 1);

    set_ts(100); i_slot_en = 4'b1111;
    @(negedge adc_clk); i_sync = 1'b1;
    @(negedge adc_clk); i_sync = 1'b0;
    repeat (39) @(negedge adc_clk);
    chk("midscan_capt_open", int'(o_capt_en), 1);
    #2 rst_n = 1'b0;
    #1 chk("midscan_reset_outputs", int'({o_slot, o_slot_sync, o_dac_load, o_fire, o_capt_en,
                                         o_busy, o_complete, o_overrun}), 0);
    @(negedge adc_clk); #2 rst_n = 1'b1;
    repeat (30) @(negedge adc_clk);
    chk("post_reset_idle", int'(o_busy), 0);

    for (int c = 0; c < 20000; c++) begin
      @(negedge adc_clk);
      i_sync = ($urandom_range(0, 39) == 0);
      i_clr_overrun = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) begin
        i_slot_en = 4'($urandom_range(0, 15));
        i_ts_time_0 = 16'($urandom_range(0, 90));
        i_ts_time_1 = 16'($urandom_range(0, 90));
        i_ts_time_2 = 16'($urandom_range(0, 90));
        i_ts_time_3 = 16'($urandom_range(0, 90));
        i_capt_delay = rnd_param();
        i_capt_len = rnd_param();
      end
      if ($urandom_range(0, 2999) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    i_sync = 1'b0; i_clr_overrun = 1'b0;
    repeat (2) @(negedge adc_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
